decim_stage_scheduler: RTL and testbench
========================================

DECIM_STAGE_SCHEDULER -- requirements
Module: decim_stage_scheduler

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of cascaded decimate-by-2 stages time-shared on one FIR engine.
REQ-002 Parameter TIMEOUT, default 64, maximum number of cycles spent in WAIT before the job is abandoned.
REQ-003 clk_in  input  1  sole clock, 100 MHz system clock.
REQ-004 rst_in  input  1  asynchronous, active-high reset.
REQ-005 sample_valid_in  input  1  single-cycle strobe, at most one per 3 MHz tick.
REQ-006 sample_in  input  16  signed PDM-mapped sample for stage 0.
REQ-007 right_shift_in  input  4  output scaling, passed through to the engine.
REQ-008 eng_start  output  1  single-cycle job-start strobe to the engine.
REQ-009 eng_stage  output  $clog2(NUM_STAGES)  stage index selecting the engine's coefficient/delay-line bank.
REQ-010 eng_data  output  16  signed sample for the job.
REQ-011 eng_shift  output  4  right_shift_in captured at ISSUE.
REQ-012 eng_emit  output  1  1 = the job completes a decimation pair and its result is forwarded.
REQ-013 eng_done  input  1  single-cycle job-complete strobe from the engine.
REQ-014 eng_result  input  16  signed filtered result, valid with eng_done.
REQ-015 out_valid  output  1  single-cycle strobe: final-stage decimated sample.
REQ-016 out_data  output  16  signed final sample, held until the next out_valid.
REQ-017 overrun_out  output  1  sticky flag: a pending sample was dropped.
REQ-018 timeout_out  output  1  sticky flag: an engine job timed out.
REQ-019 busy_out  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 Each stage s SHALL have a pending slot (pend_v[s], pend_d[s]) and a phase bit ph[s].
REQ-021 sample_valid_in SHALL load sample_in into pend_d[0] and set pend_v[0] on the next edge.
REQ-022 The FSM states SHALL be IDLE, ISSUE, WAIT and WB.
  - IDLE -> ISSUE when any pend_v is set.
  - ISSUE -> WAIT after one cycle.
  - WAIT -> WB on eng_done.
  - WAIT -> IDLE on timeout.
  - WB -> IDLE after one cycle.
REQ-023 In IDLE, arbitration SHALL be fixed priority, highest stage index first (drain deepest); the winner is latched as cur.
REQ-024 In ISSUE the block SHALL:
  - pulse eng_start with eng_stage=cur, eng_data=pend_d[cur], eng_emit=ph[cur];
  - clear pend_v[cur];
  - toggle ph[cur].
REQ-025 eng_stage, eng_data, eng_shift and eng_emit SHALL remain stable from ISSUE until leaving WAIT.
REQ-026 In WB, if the latched emit=1 and cur<NUM_STAGES-1, eng_result SHALL be written to pend_d[cur+1] and pend_v[cur+1] set.
REQ-027 In WB, if the latched emit=1 and cur=NUM_STAGES-1, out_data SHALL be set to eng_result and out_valid pulsed for one cycle.
REQ-028 In WB, if the latched emit=0, the result SHALL be discarded, since the engine has only updated its delay line.
REQ-029 A write to a slot whose pend_v is already set SHALL drop the new sample, keep the old one, and set overrun_out.
REQ-030 If sample_valid_in coincides with the ISSUE that clears pend_v[0], the new sample SHALL be accepted with no overrun.
REQ-031 eng_done outside WAIT SHALL be ignored.
REQ-032 When the WAIT cycle counter reaches TIMEOUT, the block SHALL set timeout_out, discard the job and return to IDLE; ph[cur] SHALL stay toggled.
REQ-033 Each job SHALL add 3 cycles of scheduler overhead: ISSUE, the cycle that samples eng_done, and WB.
REQ-034 The final output rate SHALL be the input rate / 2^NUM_STAGES.

Reset
REQ-035 rst_in SHALL asynchronously force the following, with no partial job surviving:
  - state IDLE;
  - all pend_v=0 and ph=0;
  - eng_start=0, out_valid=0, out_data=0;
  - overrun_out=0, timeout_out=0;
  - wait counter=0.
REQ-036 After rst_in deasserts, the first sample_valid_in SHALL be the first accepted sample.

Structure
REQ-037 A shared package SHALL hold the state enum, the NUM_STAGES/TIMEOUT defaults and the sample width (16).
REQ-038 The fixed-priority picker SHALL be a sub-module named stage_priority_pick (pend_v in, index and any-valid out).
REQ-039 The FIR engine SHALL be external; this block contains no arithmetic beyond counters.

Verification
REQ-040 Scenario: reset, then 16 samples of 0x0100 spaced 32 cycles apart, with an engine model that echoes data after 5 cycles -> exactly one out_valid, out_data=0x0100, no flags set.
REQ-041 Scenario: stage-3 pending and a stage-0 sample both valid in IDLE -> eng_stage=3 is issued first, then eng_stage=0.
REQ-042 Scenario: engine model never raises eng_done -> timeout_out rises exactly 64 cycles after WAIT entry, FSM returns to IDLE and the next job issues.
REQ-043 Scenario: 2 samples 2 cycles apart with an engine latency of 10 -> overrun_out=1 and pend_d[0] holds the first sample.
REQ-044 Scenario: rst_in asserted mid-WAIT -> all outputs are 0 immediately, asynchronously, and a late eng_done after reset is ignored.
REQ-045 Scenario: sample_valid_in coincident with ISSUE of stage 0 -> sample accepted and overrun_out stays 0.

Source files
------------

// File: rtl/decim_stage_scheduler_pkg.sv
// Shared types and defaults for the time-shared decimation-stage scheduler.
// The FIR engine itself lives outside this block.
package decim_stage_scheduler_pkg;

  localparam int unsigned DefNumStages = 4;
  localparam int unsigned DefTimeout   = 64;
  localparam int unsigned SampleW      = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StWb
  } state_e;

endpackage

// File: rtl/stage_priority_pick.sv
// Fixed-priority picker: the highest-indexed pending stage wins, so the deepest
// stage drains first.
module stage_priority_pick #(
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic [NUM_STAGES-1:0]         pend_v,
  output logic [$clog2(NUM_STAGES)-1:0] index,
  output logic                          any_valid
);

  localparam int unsigned IdxW = $clog2(NUM_STAGES);

  always_comb begin
    index     = '0;
    any_valid = 1'b0;
    // Ascending scan: a later (higher) hit overrides an earlier one.
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (pend_v[i]) begin
        index     = IdxW'(i);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decim_stage_scheduler.sv
// Schedules cascaded decimate-by-2 stages onto one shared FIR engine: each stage
// holds one pending sample and a phase bit; every second job of a stage is forwarded.
module decim_stage_scheduler
  import decim_stage_scheduler_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DefNumStages,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          sample_valid_in,
  input  logic [SampleW-1:0]            sample_in,
  input  logic [3:0]                    right_shift_in,
  output logic                          eng_start,
  output logic [$clog2(NUM_STAGES)-1:0] eng_stage,
  output logic [SampleW-1:0]            eng_data,
  output logic [3:0]                    eng_shift,
  output logic                          eng_emit,
  input  logic                          eng_done,
  input  logic [SampleW-1:0]            eng_result,
  output logic                          out_valid,
  output logic [SampleW-1:0]            out_data,
  output logic                          overrun_out,
  output logic                          timeout_out,
  output logic                          busy_out
);

  localparam int unsigned StageW = $clog2(NUM_STAGES);
  localparam int unsigned CntW   = $clog2(TIMEOUT + 1);
  localparam logic [StageW-1:0] LastStage = StageW'(NUM_STAGES - 1);
  localparam logic [CntW-1:0]   CntLast   = CntW'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [NUM_STAGES-1:0] pend_v_q, pend_v_d;
  logic [SampleW-1:0]    pend_d_q [NUM_STAGES];
  logic [SampleW-1:0]    pend_d_d [NUM_STAGES];
  logic [NUM_STAGES-1:0] ph_q, ph_d;

  logic [StageW-1:0]  cur_q, cur_d;
  logic [SampleW-1:0] job_data_q, job_data_d;
  logic [3:0]         job_shift_q, job_shift_d;
  logic               job_emit_q, job_emit_d;
  logic [SampleW-1:0] result_q, result_d;
  logic [CntW-1:0]    wait_cnt_q, wait_cnt_d;

  logic               out_valid_q, out_valid_d;
  logic [SampleW-1:0] out_data_q, out_data_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  logic [StageW-1:0] pick_idx;
  logic              pick_any;
  logic [StageW-1:0] next_stage;
  logic              wait_expired;

  stage_priority_pick #(
    .NUM_STAGES (NUM_STAGES)
  ) u_pick (
    .pend_v    (pend_v_q),
    .index     (pick_idx),
    .any_valid (pick_any)
  );

  assign next_stage   = cur_q + 1'b1;
  assign wait_expired = (state_q == StWait) && !eng_done && (wait_cnt_q == CntLast);

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_any) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (eng_done) begin
          state_d = StWb;
        end else if (wait_expired) begin
          state_d = StIdle;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    eng_start = (state_q == StIssue);
    busy_out  = (state_q != StIdle);
  end

  always_comb begin
    pend_v_d    = pend_v_q;
    pend_d_d    = pend_d_q;
    ph_d        = ph_q;
    cur_d       = cur_q;
    job_data_d  = job_data_q;
    job_shift_d = job_shift_q;
    job_emit_d  = job_emit_q;
    result_d    = result_q;
    wait_cnt_d  = wait_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;

    // Job fields are frozen here so later slot writes cannot disturb the engine bus.
    if (state_q == StIdle && pick_any) begin
      cur_d       = pick_idx;
      job_data_d  = pend_d_q[pick_idx];
      job_emit_d  = ph_q[pick_idx];
      job_shift_d = right_shift_in;
    end

    if (state_q == StIssue) begin
      pend_v_d[cur_q] = 1'b0;
      ph_d[cur_q]     = ~ph_q[cur_q];
      wait_cnt_d      = '0;
    end

    if (state_q == StWait) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      if (eng_done) begin
        result_d = eng_result;
      end
      if (wait_expired) begin
        timeout_d = 1'b1;
      end
    end

    if (state_q == StWb && job_emit_q) begin
      if (cur_q == LastStage) begin
        out_valid_d = 1'b1;
        out_data_d  = result_q;
      end else if (pend_v_q[next_stage]) begin
        overrun_d = 1'b1;
      end else begin
        pend_v_d[next_stage] = 1'b1;
        pend_d_d[next_stage] = result_q;
      end
    end

    // pend_v_d[0] already reflects a same-cycle ISSUE clear, so that case is accepted.
    if (sample_valid_in) begin
      if (pend_v_d[0]) begin
        overrun_d = 1'b1;
      end else begin
        pend_v_d[0] = 1'b1;
        pend_d_d[0] = sample_in;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pend_v_q    <= '0;
      ph_q        <= '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        pend_d_q[i] <= '0;
      end
      cur_q       <= '0;
      job_data_q  <= '0;
      job_shift_q <= '0;
      job_emit_q  <= 1'b0;
      result_q    <= '0;
      wait_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      pend_v_q    <= pend_v_d;
      ph_q        <= ph_d;
      pend_d_q    <= pend_d_d;
      cur_q       <= cur_d;
      job_data_q  <= job_data_d;
      job_shift_q <= job_shift_d;
      job_emit_q  <= job_emit_d;
      result_q    <= result_d;
      wait_cnt_q  <= wait_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign eng_stage   = cur_q;
  assign eng_data    = job_data_q;
  assign eng_shift   = job_shift_q;
  assign eng_emit    = job_emit_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign overrun_out = overrun_q;
  assign timeout_out = timeout_q;

endmodule

// File: tb/tb_decim_stage_scheduler.sv
// Bench for decim_stage_scheduler: engine model plus a decimation-chain reference.
module tb_decim_stage_scheduler;

  localparam int unsigned NStages = 4;
  localparam int unsigned Timeout = 64;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        sample_valid_in;
  logic [15:0] sample_in;
  logic [3:0]  right_shift_in;
  logic        eng_start;
  logic [1:0]  eng_stage;
  logic [15:0] eng_data;
  logic [3:0]  eng_shift;
  logic        eng_emit;
  logic        eng_done;
  logic [15:0] eng_result;
  logic        out_valid;
  logic [15:0] out_data;
  logic        overrun_out;
  logic        timeout_out;
  logic        busy_out;

  decim_stage_scheduler #(
    .NUM_STAGES (NStages),
    .TIMEOUT    (Timeout)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_valid_in (sample_valid_in),
    .sample_in       (sample_in),
    .right_shift_in  (right_shift_in),
    .eng_start       (eng_start),
    .eng_stage       (eng_stage),
    .eng_data        (eng_data),
    .eng_shift       (eng_shift),
    .eng_emit        (eng_emit),
    .eng_done        (eng_done),
    .eng_result      (eng_result),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .overrun_out     (overrun_out),
    .timeout_out     (timeout_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  int eng_latency = 5;
  bit eng_hang    = 1'b0;
  bit eng_xor     = 1'b0;

  typedef struct packed {
    logic [1:0]  stage;
    logic [15:0] data;
    logic        emit;
    logic [3:0]  shift;
  } job_t;

  job_t        jobs[$];
  logic [15:0] outs[$];
  job_t        mon_j;
  logic [15:0] eng_r;

  function automatic logic [15:0] stage_key(int s);
    logic [15:0] k;
    k = 16'h1111;
    return k << s;
  endfunction

  // Accumulated engine transform applied by stages 0..s-1.
  function automatic logic [15:0] cum_key(int s);
    logic [15:0] k;
    k = '0;
    for (int i = 0; i < s; i++) k = k ^ stage_key(i);
    return k;
  endfunction

  // Engine model: fixed latency, optional per-stage xor so stage paths are distinguishable.
  initial begin
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk_in);
      if (eng_start === 1'b1 && !eng_hang) begin
        eng_r = eng_xor ? (eng_data ^ stage_key(int'(eng_stage))) : eng_data;
        repeat (eng_latency - 1) @(negedge clk_in);
        eng_done   = 1'b1;
        eng_result = eng_r;
        @(negedge clk_in);
        eng_done   = 1'b0;
      end
    end
  end

  always @(negedge clk_in) begin
    if (eng_start === 1'b1) begin
      mon_j.stage = eng_stage;
      mon_j.data  = eng_data;
      mon_j.emit  = eng_emit;
      mon_j.shift = eng_shift;
      jobs.push_back(mon_j);
    end
    if (out_valid === 1'b1) outs.push_back(out_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in          = 1'b1;
    sample_valid_in = 1'b0;
    eng_hang        = 1'b0;
    repeat (2) tick();
    rst_in = 1'b0;
    tick();
    jobs.delete();
    outs.delete();
  endtask

  task automatic send_sample(input logic [15:0] d);
    sample_valid_in = 1'b1;
    sample_in       = d;
    tick();
    sample_valid_in = 1'b0;
  endtask

  task automatic wait_job_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (eng_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_in          = 1'b1;
    sample_valid_in = 1'b0;
    sample_in       = '0;
    right_shift_in  = '0;
    repeat (2) tick();
    checks++;
    if ({eng_start, eng_emit, out_valid, overrun_out, timeout_out, busy_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {eng_start, eng_emit, out_valid, overrun_out, timeout_out, busy_out});
    end
    checks++;
    if ({eng_stage, eng_data, eng_shift, out_data} !== 38'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h want 0", {eng_stage, eng_data, eng_shift, out_data});
    end
    rst_in = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy_out, eng_start} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy/start got %b want 00", {busy_out, eng_start});
    end
  endtask

  task automatic test_decimation();
    do_reset();
    eng_xor        = 1'b0;
    eng_latency    = 5;
    right_shift_in = 4'h3;
    for (int i = 0; i < 16; i++) begin
      send_sample(16'h0100);
      repeat (31) tick();
    end
    repeat (60) tick();
    checks++;
    if (outs.size() !== 1) begin
      errors++;
      $display("FAIL decim_out_count: got %0d want 1", outs.size());
    end
    checks++;
    if (out_data !== 16'h0100) begin
      errors++;
      $display("FAIL decim_out_data: got %h want 0100", out_data);
    end
    checks++;
    if ({overrun_out, timeout_out, busy_out} !== 3'b000) begin
      errors++;
      $display("FAIL decim_flags: got %b want 000", {overrun_out, timeout_out, busy_out});
    end
    checks++;
    if (jobs.size() !== 30) begin
      errors++;
      $display("FAIL decim_job_count: got %0d want 30", jobs.size());
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] xs [48];
    int          cnt [4];
    int          s, span, idx;
    logic [3:0]  shift;
    logic [20:0] exp_v;
    do_reset();
    eng_xor        = 1'b1;
    eng_latency    = 5;
    shift          = 4'($urandom);
    right_shift_in = shift;
    for (int i = 0; i < 48; i++) begin
      xs[i] = 16'($urandom);
      send_sample(xs[i]);
      repeat ($urandom_range(45, 34)) tick();
    end
    repeat (80) tick();
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    // Stage s sees every 2^s-th input, transformed by stages below it; odd jobs emit.
    foreach (jobs[i]) begin
      s    = int'(jobs[i].stage);
      span = 1 << s;
      idx  = cnt[s] * span + span - 1;
      checks++;
      if (idx >= 48) begin
        errors++;
        $display("FAIL rand_job_extra: stage %0d job %0d beyond input stream", s, cnt[s]);
      end else begin
        exp_v = {xs[idx] ^ cum_key(s), 1'(cnt[s] % 2), shift};
        if ({jobs[i].data, jobs[i].emit, jobs[i].shift} !== exp_v) begin
          errors++;
          $display("FAIL rand_job: stage %0d job %0d got %h want %h", s, cnt[s],
                   {jobs[i].data, jobs[i].emit, jobs[i].shift}, exp_v);
        end
      end
      cnt[s]++;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cnt[k] !== (48 >> k)) begin
        errors++;
        $display("FAIL rand_stage_jobs: stage %0d got %0d want %0d", k, cnt[k], 48 >> k);
      end
    end
    checks++;
    if (outs.size() !== 3) begin
      errors++;
      $display("FAIL rand_out_count: got %0d want 3", outs.size());
    end
    for (int m = 0; m < 3 && m < outs.size(); m++) begin
      checks++;
      if (outs[m] !== (xs[16 * m + 15] ^ cum_key(4))) begin
        errors++;
        $display("FAIL rand_out: #%0d got %h want %h", m, outs[m], xs[16 * m + 15] ^ cum_key(4));
      end
    end
    checks++;
    if ({overrun_out, timeout_out} !== 2'b00) begin
      errors++;
      $display("FAIL rand_flags: got %b want 00", {overrun_out, timeout_out});
    end
  endtask

  task automatic test_priority();
    int base;
    int exp_st [5];
    exp_st = '{0, 1, 2, 3, 0};
    do_reset();
    eng_xor     = 1'b0;
    eng_latency = 5;
    for (int i = 0; i < 7; i++) begin
      send_sample(16'(i + 1));
      repeat (40) tick();
    end
    base = jobs.size();
    send_sample(16'h0008);
    repeat (10) tick();
    send_sample(16'h0009);
    repeat (80) tick();
    checks++;
    if (jobs.size() - base !== 5) begin
      errors++;
      $display("FAIL prio_job_count: got %0d want 5", jobs.size() - base);
    end
    for (int k = 0; k < 5 && base + k < jobs.size(); k++) begin
      checks++;
      if (int'(jobs[base + k].stage) !== exp_st[k]) begin
        errors++;
        $display("FAIL prio_order: job %0d stage got %0d want %0d", k,
                 jobs[base + k].stage, exp_st[k]);
      end
    end
    checks++;
    if (overrun_out !== 1'b0) begin
      errors++;
      $display("FAIL prio_overrun: got %b want 0", overrun_out);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    eng_hang    = 1'b1;
    eng_latency = 5;
    send_sample(16'hA5A5);
    wait_job_start(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo_first_start: no eng_start within budget");
    end
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk_in);
      if (k == 10) begin
        sample_valid_in = 1'b1;
        sample_in       = 16'h5A5A;
      end
      if (k == 11) sample_valid_in = 1'b0;
      if (k == 64) begin
        checks++;
        if ({timeout_out, busy_out} !== 2'b01) begin
          errors++;
          $display("FAIL tmo_before: timeout/busy got %b want 01", {timeout_out, busy_out});
        end
      end
      if (k == 65) begin
        checks++;
        if ({timeout_out, busy_out} !== 2'b10) begin
          errors++;
          $display("FAIL tmo_at64: timeout/busy got %b want 10", {timeout_out, busy_out});
        end
      end
    end
    eng_hang = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({eng_start, eng_stage, eng_data, eng_emit} !== {1'b1, 2'd0, 16'h5A5A, 1'b1}) begin
      errors++;
      $display("FAIL tmo_next_job: got %h want %h", {eng_start, eng_stage, eng_data, eng_emit},
               {1'b1, 2'd0, 16'h5A5A, 1'b1});
    end
    repeat (40) tick();
    checks++;
    if ({timeout_out, overrun_out, busy_out} !== 3'b100) begin
      errors++;
      $display("FAIL tmo_sticky: got %b want 100", {timeout_out, overrun_out, busy_out});
    end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    eng_latency = 10;
    send_sample(16'h1111);
    wait_job_start(ok);
    tick();
    send_sample(16'h2222);
    tick();
    checks++;
    if (overrun_out !== 1'b0) begin
      errors++;
      $display("FAIL ovr_early: got %b want 0", overrun_out);
    end
    send_sample(16'h3333);
    checks++;
    if (overrun_out !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: got %b want 1", overrun_out);
    end
    wait_job_start(ok);
    checks++;
    if (!ok || {eng_stage, eng_data, eng_emit} !== {2'd0, 16'h2222, 1'b1}) begin
      errors++;
      $display("FAIL ovr_kept_old: ok %0d got %h want %h", ok, {eng_stage, eng_data, eng_emit},
               {2'd0, 16'h2222, 1'b1});
    end
    repeat (40) tick();
    checks++;
    if ({overrun_out, timeout_out} !== 2'b10) begin
      errors++;
      $display("FAIL ovr_sticky: got %b want 10", {overrun_out, timeout_out});
    end
  endtask

  task automatic test_coincident();
    bit ok;
    do_reset();
    eng_latency = 5;
    send_sample(16'h0A0A);
    wait_job_start(ok);
    sample_valid_in = 1'b1;
    sample_in       = 16'h0B0B;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    checks++;
    if (overrun_out !== 1'b0) begin
      errors++;
      $display("FAIL coin_overrun: got %b want 0", overrun_out);
    end
    wait_job_start(ok);
    checks++;
    if (!ok || {eng_stage, eng_data, eng_emit} !== {2'd0, 16'h0B0B, 1'b1}) begin
      errors++;
      $display("FAIL coin_accept: ok %0d got %h want %h", ok, {eng_stage, eng_data, eng_emit},
               {2'd0, 16'h0B0B, 1'b1});
    end
    repeat (30) tick();
    checks++;
    if (overrun_out !== 1'b0) begin
      errors++;
      $display("FAIL coin_overrun_late: got %b want 0", overrun_out);
    end
  endtask

  task automatic test_reset_midwait();
    bit ok;
    bit saw_activity;
    do_reset();
    eng_latency    = 10;
    right_shift_in = 4'hF;
    send_sample(16'hCAFE);
    wait_job_start(ok);
    tick();
    send_sample(16'h1234);
    tick();
    send_sample(16'h5678);
    @(negedge clk_in);
    checks++;
    if ({busy_out, overrun_out} !== 2'b11) begin
      errors++;
      $display("FAIL rmw_pre: busy/overrun got %b want 11", {busy_out, overrun_out});
    end
    rst_in = 1'b1;
    #1;
    checks++;
    if ({eng_start, eng_emit, out_valid, overrun_out, timeout_out, busy_out} !== 6'b0) begin
      errors++;
      $display("FAIL rmw_async_flags: got %b want 000000",
               {eng_start, eng_emit, out_valid, overrun_out, timeout_out, busy_out});
    end
    checks++;
    if ({eng_stage, eng_data, eng_shift, out_data} !== 38'h0) begin
      errors++;
      $display("FAIL rmw_async_buses: got %h want 0", {eng_stage, eng_data, eng_shift, out_data});
    end
    repeat (2) tick();
    rst_in       = 1'b0;
    saw_activity = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      if (busy_out !== 1'b0 || eng_start !== 1'b0 || out_valid !== 1'b0) saw_activity = 1'b1;
    end
    checks++;
    if (saw_activity !== 1'b0) begin
      errors++;
      $display("FAIL rmw_late_done: activity after reset got 1 want 0");
    end
    right_shift_in = 4'h2;
    send_sample(16'h0042);
    wait_job_start(ok);
    checks++;
    if (!ok || {eng_stage, eng_data, eng_emit, eng_shift} !== {2'd0, 16'h0042, 1'b0, 4'h2}) begin
      errors++;
      $display("FAIL rmw_first_sample: ok %0d got %h want %h", ok,
               {eng_stage, eng_data, eng_emit, eng_shift}, {2'd0, 16'h0042, 1'b0, 4'h2});
    end
    repeat (20) tick();
  endtask

  initial begin
    rst_in          = 1'b1;
    sample_valid_in = 1'b0;
    sample_in       = '0;
    right_shift_in  = '0;
    test_reset();
    test_decimation();
    test_random_stream();
    test_priority();
    test_timeout();
    test_overrun();
    test_coincident();
    test_reset_midwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
